// File: rtl/brew_stage_timer.sv
// rtl/brew_stage_timer.sv - stage timer counting tick_in rising edges with done/abort pulses and LED status
module brew_stage_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             start,
    input  logic [CNT_W-1:0] duration,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] remaining,
    output logic [7:3]       led
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    logic   tick_q;
    logic   done_flag;
    logic   rise;

    assign rise = tick_in & ~tick_q;
    assign led  = {busy, done_flag, remaining[2:0]};

    // tick_q tracks tick_in even in reset so a high level at release is not an edge
    always_ff @(posedge clk) begin
        tick_q <= tick_in;
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            remaining <= '0;
            done_flag <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        remaining <= duration;
                        busy      <= 1'b1;
                        done_flag <= 1'b0;
                        state     <= (duration == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                        aborted   <= 1'b1;
                    end else if (rise) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    done_flag <= 1'b1;
                    remaining <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brew_stage_timer.sv
// tb/tb_brew_stage_timer.sv - randomized bench for brew_stage_timer against a behavioural stage model
module tb_brew_stage_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick_in;
    logic         start;
    logic [W-1:0] duration;
    logic         abort;
    logic         busy;
    logic         done;
    logic         aborted;
    logic [W-1:0] remaining;
    logic [7:3]   led;

    int checks = 0;
    int errors = 0;
    int phase  = 0;

    // behavioural model: a stage is either idle, counting, or owed a done pulse
    logic         m_busy, m_done, m_aborted, m_flag, m_owed, m_prev_tick;
    int           m_rem;

    always #5 clk = ~clk;

    brew_stage_timer #(.CNT_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_in  (tick_in),
        .start    (start),
        .duration (duration),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .remaining(remaining),
        .led      (led)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic fresh_edge;
        fresh_edge  = tick_in && !m_prev_tick;
        m_prev_tick = tick_in;
        m_done      = 1'b0;
        m_aborted   = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_flag = 1'b0; m_owed = 1'b0; m_rem = 0;
        end else if (m_owed) begin
            m_owed = 1'b0; m_done = 1'b1; m_busy = 1'b0; m_flag = 1'b1; m_rem = 0;
        end else if (!m_busy) begin
            if (start && !abort) begin
                m_busy = 1'b1; m_flag = 1'b0; m_rem = int'(duration);
                m_owed = (duration == 0);
            end
        end else if (abort) begin
            m_busy = 1'b0; m_rem = 0; m_aborted = 1'b1;
        end else if (fresh_edge) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_owed = 1'b1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("aborted", 32'(aborted), 32'(m_aborted));
        check("remaining", 32'(remaining), 32'(m_rem));
        check("led", 32'(led), 32'({m_busy, m_flag, m_rem[2:0]}));
    endtask

    task automatic wave(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            tick_in = ((phase % per) < (per / 2));
            phase++;
            cyc();
        end
    endtask

    task automatic go(input int d);
        start = 1'b1; duration = W'(d);
        cyc();
        start = 1'b0;
    endtask

    initial begin
        int per;
        rst = 1'b1; tick_in = 1'b1; start = 1'b0; duration = '0; abort = 1'b0;
        m_busy = 0; m_done = 0; m_aborted = 0; m_flag = 0; m_owed = 0; m_prev_tick = 0; m_rem = 0;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (3) cyc();
        check("no_edge_after_reset", 32'(remaining), 32'd0);

        // duration 3 entered with tick already high: needs three fresh rises
        go(3);
        check("loaded_3", 32'(remaining), 32'd3);
        phase = 4;
        wave(40, 8);

        go(5);
        wave(60, 8);
        check("flag_after_5", 32'(led[6]), 32'd1);

        go(0);
        check("zero_busy", 32'(busy), 32'd1);
        cyc();
        check("zero_done", 32'(done), 32'd1);
        repeat (2) cyc();

        go(4);
        wave(9, 4);
        abort = 1'b1; cyc(); abort = 1'b0;
        check("abort_pulse", 32'(aborted), 32'd1);
        wave(10, 4);

        // final rise coinciding with abort
        tick_in = 1'b0;
        go(1);
        cyc();
        tick_in = 1'b1; abort = 1'b1; cyc(); abort = 1'b0;
        check("abort_beats_last_rise", 32'(aborted), 32'd1);
        repeat (3) cyc();

        start = 1'b1; abort = 1'b1; duration = 8'd7; cyc();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'd0);

        go(6);
        for (int i = 0; i < 6; i++) begin
            start = 1'b1; duration = 8'd2;
            wave(3, 6);
        end
        start = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        check("rst_mid_run", 32'(busy), 32'd0);
        cyc();

        go(255);
        wave(515, 2);
        repeat (3) cyc();

        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0) per = 2 + 2 * $urandom_range(0, 4);
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 29) == 0);
            duration = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 7));
            if (i % 1000 < 500) tick_in = ((phase % per) < (per / 2));
            else                tick_in = ($urandom_range(0, 2) == 0) ? ~tick_in : tick_in;
            phase++;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
